// File: rtl/tdm_demux4_if.sv
// Serial-lane-in / parallel-frame-out bundle for the 4-slot TDM demultiplexer.
//   master : drives din/din_valid/sof and observes the frame outputs.
//   slave  : the demultiplexer; consumes the lane and drives the frame outputs.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               sof;
  logic [4*WIDTH-1:0] dout;
  logic               dout_valid;
  logic [1:0]         slot;
  logic               locked;
  logic               frame_err;
  logic [CNT_W-1:0]   frame_cnt;

  modport master (
    output din, din_valid, sof,
    input  dout, dout_valid, slot, locked, frame_err, frame_cnt
  );

  modport slave (
    input  din, din_valid, sof,
    output dout, dout_valid, slot, locked, frame_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot time-division demultiplexer. Samples arriving one per valid beat on
// a shared lane are reassembled into a 4-lane frame (lane k = slot k), with
// slot-0 alignment taken from sof.
// Ports:
//   clk, rst_n       : rising-edge clock, async active-low reset
//   bus.din          : slot sample          bus.din_valid : beat qualifier
//   bus.sof          : beat is slot 0       bus.dout      : last good frame
//   bus.dout_valid   : 1-cycle frame pulse  bus.slot      : next expected slot
//   bus.locked       : aligned (COLLECT)    bus.frame_err : 1-cycle error pulse
//   bus.frame_cnt    : completed frames, wrapping
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             state;
  logic [1:0]         slot_q;
  logic [WIDTH-1:0]   lane0;
  logic [WIDTH-1:0]   lane1;
  logic [WIDTH-1:0]   lane2;
  logic [4*WIDTH-1:0] dout_q;
  logic               dout_valid_q;
  logic               frame_err_q;
  logic [CNT_W-1:0]   frame_cnt_q;

  // Slot tracking, shadow lanes and frame output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      slot_q       <= 2'd0;
      lane0        <= '0;
      lane1        <= '0;
      lane2        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            // Non-sof beats while hunting are silently dropped.
            if (bus.sof) begin
              lane0  <= bus.din;
              slot_q <= 2'd1;
              state  <= COLLECT;
            end
          end
          COLLECT: begin
            if (bus.sof) begin
              // sof mid-frame abandons the partial frame and realigns here.
              if (slot_q != 2'd0) frame_err_q <= 1'b1;
              lane0  <= bus.din;
              slot_q <= 2'd1;
            end else if (slot_q == 2'd0) begin
              // Expected slot 0 but no sof: alignment lost.
              frame_err_q <= 1'b1;
              slot_q      <= 2'd0;
              state       <= HUNT;
            end else if (slot_q == 2'd3) begin
              dout_q       <= {bus.din, lane2, lane1, lane0};
              dout_valid_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
              slot_q       <= 2'd0;
            end else begin
              if (slot_q == 2'd1) lane1 <= bus.din;
              else                lane2 <= bus.din;
              slot_q <= slot_q + 2'd1;
            end
          end
          default: begin
            state  <= HUNT;
            slot_q <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = (state == COLLECT);
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a CNT_W=8 instance (a) and a CNT_W=2
// instance (b) receive identical stimulus; b exercises counter wrap.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;
  int   nframes;

  tdm_demux4_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  tdm_demux4_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

  tdm_demux4 #(.WIDTH(4), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  tdm_demux4 #(.WIDTH(4), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on both lanes; return #1 after the sampling edge.
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    bus_a.din_valid = v; bus_a.sof = s; bus_a.din = d;
    bus_b.din_valid = v; bus_b.sof = s; bus_b.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt_a"}, 32'(bus_a.frame_cnt), 32'(nframes % 256));
    check({tag, "_cnt_b"}, 32'(bus_b.frame_cnt), 32'(nframes % 4));
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_dout"},   32'(bus_a.dout),       32'h0);
    check({tag, "_dv"},     32'(bus_a.dout_valid), 32'h0);
    check({tag, "_locked"}, 32'(bus_a.locked),     32'h0);
    check({tag, "_slot"},   32'(bus_a.slot),       32'h0);
    check({tag, "_ferr"},   32'(bus_a.frame_err),  32'h0);
    check_cnt(tag);
  endtask

  // Send a clean 4-beat frame whose expected dout is f (slot k = f[4k+:4]).
  task automatic send_frame(input string tag, input logic [15:0] f);
    logic [15:0] fr;
    fr = f;
    step(1'b1, 1'b1, fr[3:0]);
    check({tag, "_b0_dv"}, 32'(bus_a.dout_valid), 32'h0);
    check({tag, "_b0_slot"}, 32'(bus_a.slot), 32'h1);
    step(1'b1, 1'b0, fr[7:4]);
    check({tag, "_b1_dv"}, 32'(bus_a.dout_valid), 32'h0);
    step(1'b1, 1'b0, fr[11:8]);
    check({tag, "_b2_dv"}, 32'(bus_a.dout_valid), 32'h0);
    check({tag, "_b2_slot"}, 32'(bus_a.slot), 32'h3);
    step(1'b1, 1'b0, fr[15:12]);
    nframes++;
    check({tag, "_dv"},   32'(bus_a.dout_valid), 32'h1);
    check({tag, "_dout"}, 32'(bus_a.dout),       32'(fr));
    check({tag, "_ferr"}, 32'(bus_a.frame_err),  32'h0);
    check({tag, "_slot"}, 32'(bus_a.slot),       32'h0);
    check({tag, "_lock"}, 32'(bus_a.locked),     32'h1);
    check_cnt(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    nframes = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle_reset(tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    nframes = 0;
    rst_n   = 1'b1;
    bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.sof = 1'b0;
    bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.sof = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset("por");

    // Reset then idle.
    do_reset("rst");
    step(1'b0, 1'b1, 4'h7);
    check_idle_reset("idle_sof_novalid");
    step(1'b0, 1'b0, 4'h3);
    check_idle_reset("idle");

    // Single frame.
    send_frame("single", 16'hDCBA);
    step(1'b0, 1'b0, 4'h0);
    check("single_hold_dv",   32'(bus_a.dout_valid), 32'h0);
    check("single_hold_dout", 32'(bus_a.dout),       32'hDCBA);

    // Gapped frame after a fresh reset, then three back-to-back frames.
    do_reset("rst2");
    step(1'b1, 1'b1, 4'h1);
    step(1'b0, 1'b0, 4'h0);
    check("gap_idle_slot", 32'(bus_a.slot), 32'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    check("gap_idle_dv", 32'(bus_a.dout_valid), 32'h0);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    nframes++;
    check("gap_dv",   32'(bus_a.dout_valid), 32'h1);
    check("gap_dout", 32'(bus_a.dout),       32'h4321);
    check_cnt("gap");
    send_frame("b2b0", 16'h8765);
    send_frame("b2b1", 16'h0FED);
    send_frame("b2b2", 16'h5A3C);
    check("b2b_cnt4", 32'(bus_a.frame_cnt), 32'h4);

    // Early sof discards the partial 0x5/0x6 frame.
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b0, 4'h6);
    check("early_hold_dout", 32'(bus_a.dout), 32'h5A3C);
    step(1'b1, 1'b1, 4'h7);
    check("early_ferr", 32'(bus_a.frame_err),  32'h1);
    check("early_dv",   32'(bus_a.dout_valid), 32'h0);
    check("early_slot", 32'(bus_a.slot),       32'h1);
    check("early_lock", 32'(bus_a.locked),     32'h1);
    step(1'b1, 1'b0, 4'h8);
    check("early_ferr_clr", 32'(bus_a.frame_err), 32'h0);
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'hA);
    nframes++;
    check("early_dv2",  32'(bus_a.dout_valid), 32'h1);
    check("early_dout", 32'(bus_a.dout),       32'hA987);
    check_cnt("early");

    // Missing sof drops lock; non-sof beats then ignored; sof relocks.
    step(1'b1, 1'b0, 4'hF);
    check("miss_ferr", 32'(bus_a.frame_err), 32'h1);
    check("miss_lock", 32'(bus_a.locked),    32'h0);
    check("miss_slot", 32'(bus_a.slot),      32'h0);
    check("miss_dout", 32'(bus_a.dout),      32'hA987);
    step(1'b1, 1'b0, 4'h1);
    check("hunt_ferr", 32'(bus_a.frame_err), 32'h0);
    check("hunt_lock", 32'(bus_a.locked),    32'h0);
    step(1'b1, 1'b0, 4'h2);
    check("hunt_ferr2", 32'(bus_a.frame_err), 32'h0);
    send_frame("relock", 16'h4321);

    // Async reset after the slot-2 beat of a partial frame.
    step(1'b1, 1'b1, 4'hE);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'hC);
    check("mid_slot", 32'(bus_a.slot), 32'h3);
    #1;
    rst_n = 1'b0;
    nframes = 0;
    #1;
    check_idle_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    check_idle_reset("post_rst");

    // Counter wrap on the CNT_W=2 instance: 5 frames -> 1.
    send_frame("wrap0", 16'h1111);
    send_frame("wrap1", 16'h2222);
    send_frame("wrap2", 16'h3333);
    send_frame("wrap3", 16'h4444);
    send_frame("wrap4", 16'hF0E1);
    check("wrap_cnt_b", 32'(bus_b.frame_cnt), 32'h1);
    check("wrap_cnt_a", 32'(bus_a.frame_cnt), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
